reg_file_16: RTL and testbench

//   16-entry x WIDTH-bit register bank for the decode stage of the 5-stage pipeline.
//   - Holds the architectural registers.
//   - Feeds the per-bit 16:1 read-select muxes: one mux tree per bit per read port.
//   - Two combinational read ports and one clocked write port, driven by writeback.
//   - Write-through bypass, so a value written in WB is visible to ID in the same cycle.
//   - Register 15 is hard-wired zero.

---
 rtl/reg_file_16.sv | 149 ++++++++++++++
 tb/tb_reg_file_16.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_16.sv
// 16 x WIDTH register bank for the decode stage: two combinational read ports,
// one clocked write port from writeback, write-through bypass, r15 reads as zero.

module reg_file_16_decode #(
    parameter int ZERO_REG = 15
) (
    input  logic        en,
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);
    localparam logic [3:0] ZIDX = 4'(ZERO_REG);

    always_comb begin
        onehot = '0;
        if (en && (idx != ZIDX)) begin
            onehot[idx] = 1'b1;
        end
    end
endmodule

module reg_file_16_cell #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module reg_file_16_mux16 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);
    logic [7:0] l1;
    logic [3:0] l2;
    logic [1:0] l3;

    // Binary tree, one select bit per level
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            l1[i] = sel[0] ? in[2*i+1] : in[2*i];
        end
        for (int i = 0; i < 4; i++) begin
            l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
        end
        for (int i = 0; i < 2; i++) begin
            l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
        end
        out = sel[3] ? l3[1] : l3[0];
    end
endmodule

module reg_file_16 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic [3:0]       read_reg1,
    input  logic [3:0]       read_reg2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);
    localparam logic [3:0] ZIDX = 4'(ZERO_REG);

    logic [15:0]      wen;
    logic [WIDTH-1:0] storage [16];
    logic [WIDTH-1:0] raw1;
    logic [WIDTH-1:0] raw2;
    logic             byp1;
    logic             byp2;

    reg_file_16_decode #(
        .ZERO_REG(ZERO_REG)
    ) u_dec (
        .en    (reg_write),
        .idx   (write_reg),
        .onehot(wen)
    );

    for (genvar r = 0; r < 16; r++) begin : g_reg
        reg_file_16_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .en   (wen[r]),
            .d    (write_data),
            .q    (storage[r])
        );
    end

    // Transpose storage so each bit gets its own 16:1 tree per port
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [15:0] col;

        for (genvar r = 0; r < 16; r++) begin : g_col
            assign col[r] = storage[r][b];
        end

        reg_file_16_mux16 u_mux1 (
            .in (col),
            .sel(read_reg1),
            .out(raw1[b])
        );

        reg_file_16_mux16 u_mux2 (
            .in (col),
            .sel(read_reg2),
            .out(raw2[b])
        );
    end

    assign byp1 = reg_write && !reset && (write_reg == read_reg1);
    assign byp2 = reg_write && !reset && (write_reg == read_reg2);

    always_comb begin
        if (read_reg1 == ZIDX) begin
            read_data1 = '0;
        end else if (byp1) begin
            read_data1 = write_data;
        end else begin
            read_data1 = raw1;
        end
    end

    always_comb begin
        if (read_reg2 == ZIDX) begin
            read_data2 = '0;
        end else if (byp2) begin
            read_data2 = write_data;
        end else begin
            read_data2 = raw2;
        end
    end
endmodule

// File: tb/tb_reg_file_16.sv
// Bench for reg_file_16: directed scenarios then random traffic
// against an array model of the architectural registers.
`timescale 1ns/1ps

module tb_reg_file_16;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write = 1'b0;
    logic [3:0]  write_reg = '0;
    logic [63:0] write_data = '0;
    logic [3:0]  read_reg1 = '0;
    logic [3:0]  read_reg2 = '0;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    logic [63:0] mem [16];
    int total = 0;
    int bad = 0;

    reg_file_16 #(.WIDTH(64), .ZERO_REG(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expect_read(input logic [3:0] sel);
        if (sel == 4'd15) return 64'd0;
        if (reset) return 64'd0;
        if (reg_write && write_reg == sel) return write_data;
        return mem[sel];
    endfunction

    task automatic check_ports(input string tag);
        check($sformatf("%s.p1[r%0d]", tag, read_reg1), read_data1, expect_read(read_reg1));
        check($sformatf("%s.p2[r%0d]", tag, read_reg2), read_data2, expect_read(read_reg2));
    endtask

    task automatic sweep(input string tag, input realtime step);
        for (int i = 0; i < 16; i++) begin
            read_reg1 = 4'(i);
            read_reg2 = 4'(15 - i);
            #(step);
            check_ports(tag);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    endtask

    // One cycle: drive at negedge, check pre-edge, then apply the edge to the model
    task automatic cycle(input logic we, input logic [3:0] wr, input logic [63:0] wd,
                         input logic [3:0] r1, input logic [3:0] r2, input string tag);
        @(negedge clk);
        reg_write = we;
        write_reg = wr;
        write_data = wd;
        read_reg1 = r1;
        read_reg2 = r2;
        #1;
        check_ports(tag);
        @(posedge clk);
        if (!reset && we && wr != 4'd15) mem[wr] = wd;
    endtask

    initial begin
        clear_model();

        // Reset with no clock edge yet
        #1 reset = 1'b1;
        sweep("rst", 0.2);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Write then read
        cycle(1'b1, 4'd3, 64'h0123_4567_89AB_CDEF, 4'd0, 4'd1, "wr3");
        cycle(1'b0, 4'd0, 64'd0, 4'd3, 4'd3, "rd3");
        @(negedge clk);
        sweep("after_wr3", 0.2);

        // Zero register
        cycle(1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 4'd15, "z_wr");
        cycle(1'b0, 4'd15, 64'd0, 4'd15, 4'd15, "z_rd");
        check("zero_p1_direct", read_data1, 64'd0);

        // Bypass
        cycle(1'b1, 4'd5, 64'h11, 4'd0, 4'd0, "b_seed");
        cycle(1'b1, 4'd5, 64'h22, 4'd5, 4'd5, "bypass");
        check("bypass_p1_direct", read_data1, 64'h22);
        cycle(1'b0, 4'd5, 64'h0, 4'd5, 4'd5, "b_after");
        check("bypass_after_direct", read_data2, 64'h22);

        // Disabled write
        cycle(1'b1, 4'd7, 64'h77, 4'd0, 4'd0, "d_seed");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'd7, 64'hDEAD, 4'd7, 4'd7, "dis");
        end
        check("dis_r7_direct", read_data1, 64'h77);

        // Async reset mid-operation
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 4'(i), 64'(i + 1), 4'(i), 4'd15, "fill");
        end
        @(negedge clk);
        reg_write = 1'b1;
        write_reg = 4'd2;
        write_data = 64'hCAFE;
        #1 reset = 1'b1;
        clear_model();
        sweep("mid_rst", 0.1);
        @(posedge clk);
        #1;
        read_reg1 = 4'd2;
        read_reg2 = 4'd4;
        #0.1;
        check_ports("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_byp", read_data1, 64'hCAFE);
        @(posedge clk);
        mem[2] = 64'hCAFE;
        cycle(1'b0, 4'd0, 64'd0, 4'd2, 4'd3, "post_rst");
        check("post_rst_r2_direct", read_data1, 64'hCAFE);

        // Random traffic with occasional reset pulses between edges
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reg_write = ($urandom_range(0, 3) != 0);
            write_reg = 4'($urandom_range(0, 15));
            write_data = {$urandom, $urandom};
            read_reg1 = ($urandom_range(0, 3) == 0) ? write_reg : 4'($urandom_range(0, 15));
            read_reg2 = ($urandom_range(0, 3) == 0) ? write_reg : 4'($urandom_range(0, 15));
            #1;
            check_ports("rnd");
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                clear_model();
                #0.5;
                check_ports("rnd_rst");
                reset = 1'b0;
                #0.5;
                check_ports("rnd_rst_rel");
            end
            @(posedge clk);
            if (reg_write && write_reg != 4'd15) mem[write_reg] = write_data;
        end

        @(negedge clk);
        reg_write = 1'b0;
        sweep("final", 0.2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
